// File: rtl/rv32_pkg.sv
// ============================================================================
//  Module      : rv32_pkg
//  Description : Shared RV32M multiply/divide types and constants.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] DIV_OVF_QUOT = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES     = 32'hFFFF_FFFF;

    // RV32M funct3 encodings
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    // Iterative engine control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

endpackage

`default_nettype wire

// File: rtl/muldiv_sign_fix.sv
// ============================================================================
//  Module      : muldiv_sign_fix
//  Description : Combinational operand magnitude extraction at launch and
//                two's-complement sign correction plus result select at the
//                end of an operation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sign_fix
    import rv32_pkg::*;
(
    input  muldiv_op_e          start_op,
    input  logic [XLEN-1:0]     opa,
    input  logic [XLEN-1:0]     opb,
    output logic [XLEN-1:0]     mag_a,
    output logic [XLEN-1:0]     mag_b,
    output logic                neg_q,
    output logic                neg_r,
    input  muldiv_op_e          fix_op,
    input  logic [2*XLEN-1:0]   acc,
    input  logic                fix_neg_q,
    input  logic                fix_neg_r,
    output logic [XLEN-1:0]     fixed
);

    logic              w_sgn_a;
    logic              w_sgn_b;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;

    // Operand signedness from the opcode; magnitudes feed the unsigned core
    always_comb begin
        w_sgn_a = 1'b0;
        w_sgn_b = 1'b0;
        case (start_op)
            OP_MULH, OP_DIV, OP_REM: begin
                w_sgn_a = opa[XLEN-1];
                w_sgn_b = opb[XLEN-1];
            end
            OP_MULHSU: w_sgn_a = opa[XLEN-1];
            default: ;
        endcase
        mag_a = w_sgn_a ? -opa : opa;
        mag_b = w_sgn_b ? -opb : opb;
        neg_q = w_sgn_a ^ w_sgn_b;   // product / quotient sign
        neg_r = w_sgn_a;             // remainder follows the dividend
    end

    // Sign-correct the raw accumulator and pick the architectural word
    always_comb begin
        w_prod = fix_neg_q ? -acc : acc;
        w_quot = fix_neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        w_rem  = fix_neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        fixed  = '0;
        case (fix_op)
            OP_MUL:                       fixed = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fixed = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fixed = w_quot;
            OP_REM, OP_REMU:              fixed = w_rem;
            default:                      fixed = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_iter_unit.sv
// ============================================================================
//  Module      : muldiv_iter_unit
//  Description : Iterative RV32M multiply/divide engine, one radix-2 step per
//                cycle, stalling the pipeline through busy and returning the
//                result with a single-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_iter_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  opa,
    input  logic [XLEN-1:0]  opb,
    input  logic [4:0]       rd_in,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [4:0]       rd_out
);

    localparam logic [CNT_W-1:0] c_LAST_STEP = CNT_W'(XLEN - 1);

    rv32_pkg::muldiv_state_e r_state;
    rv32_pkg::muldiv_state_e w_state_nxt;
    rv32_pkg::muldiv_op_e    r_op;
    rv32_pkg::muldiv_op_e    w_start_op;

    logic [CNT_W-1:0]   r_cnt;
    logic [4:0]         r_rd;
    logic [XLEN-1:0]    r_div;        // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]  r_acc;        // {high/remainder, low/quotient}
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_special;
    logic [XLEN-1:0]    r_spec_val;
    logic [XLEN-1:0]    r_result;
    logic [4:0]         r_rd_out;

    logic [XLEN-1:0]    w_mag_a;
    logic [XLEN-1:0]    w_mag_b;
    logic               w_neg_q;
    logic               w_neg_r;
    logic [XLEN-1:0]    w_fixed;
    logic               w_accept;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic               w_special;
    logic [XLEN-1:0]    w_spec_val;
    logic [XLEN:0]      w_mul_sum;
    logic [2*XLEN-1:0]  w_mul_step;
    logic [XLEN:0]      w_rem_sh;
    logic               w_rem_ge;
    logic [XLEN-1:0]    w_rem_sub;
    logic [2*XLEN-1:0]  w_div_step;

    assign w_start_op = rv32_pkg::muldiv_op_e'(op);
    assign w_accept   = (r_state == rv32_pkg::ST_IDLE) && start && !flush;

    muldiv_sign_fix u_sign_fix (
        .start_op  (w_start_op),
        .opa       (opa),
        .opb       (opb),
        .mag_a     (w_mag_a),
        .mag_b     (w_mag_b),
        .neg_q     (w_neg_q),
        .neg_r     (w_neg_r),
        .fix_op    (r_op),
        .acc       (r_acc),
        .fix_neg_q (r_neg_q),
        .fix_neg_r (r_neg_r),
        .fixed     (w_fixed)
    );

    // Divides with a fixed architectural answer bypass the iteration
    always_comb begin
        w_div_zero = (opb == '0);
        w_div_ovf  = ((w_start_op == rv32_pkg::OP_DIV) || (w_start_op == rv32_pkg::OP_REM))
                     && (opa == rv32_pkg::DIV_OVF_QUOT) && (opb == rv32_pkg::ALL_ONES);
        w_special  = op[2] && (w_div_zero || w_div_ovf);
        if (w_div_zero)
            w_spec_val = op[1] ? opa : rv32_pkg::ALL_ONES;
        else
            w_spec_val = op[1] ? '0 : rv32_pkg::DIV_OVF_QUOT;
    end

    // One shift-add (multiply) and one restoring shift-subtract (divide) step
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_div} : '0);
        w_mul_step = {w_mul_sum, r_acc[XLEN-1:1]};
        w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_rem_ge   = (w_rem_sh >= {1'b0, r_div});
        w_rem_sub  = w_rem_sh[XLEN-1:0] - r_div;
        w_div_step = w_rem_ge ? {w_rem_sub, r_acc[XLEN-2:0], 1'b1}
                              : {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    end

    // Next-state and status decode; flush overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            rv32_pkg::ST_IDLE: begin
                if (start)
                    w_state_nxt = w_special ? rv32_pkg::ST_FIX : rv32_pkg::ST_CALC;
            end
            rv32_pkg::ST_CALC: begin
                busy = 1'b1;
                if (r_cnt == c_LAST_STEP)
                    w_state_nxt = rv32_pkg::ST_FIX;
            end
            rv32_pkg::ST_FIX: begin
                busy        = 1'b1;
                w_state_nxt = rv32_pkg::ST_DONE;
            end
            rv32_pkg::ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = rv32_pkg::ST_IDLE;
            end
            default: w_state_nxt = rv32_pkg::ST_IDLE;
        endcase
        if (flush)
            w_state_nxt = rv32_pkg::ST_IDLE;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= rv32_pkg::ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Datapath: latch at launch, iterate in CALC, publish in FIX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= rv32_pkg::OP_MUL;
            r_cnt      <= '0;
            r_rd       <= '0;
            r_div      <= '0;
            r_acc      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_special  <= 1'b0;
            r_spec_val <= '0;
            r_result   <= '0;
            r_rd_out   <= '0;
        end else if (w_accept) begin
            r_op       <= w_start_op;
            r_rd       <= rd_in;
            r_cnt      <= '0;
            r_div      <= op[2] ? w_mag_b : w_mag_a;
            r_acc      <= op[2] ? {{XLEN{1'b0}}, w_mag_a} : {{XLEN{1'b0}}, w_mag_b};
            r_neg_q    <= w_neg_q;
            r_neg_r    <= w_neg_r;
            r_special  <= w_special;
            r_spec_val <= w_spec_val;
        end else if ((r_state == rv32_pkg::ST_CALC) && !flush) begin
            r_acc <= r_op[2] ? w_div_step : w_mul_step;
            r_cnt <= r_cnt + CNT_W'(1);
        end else if ((r_state == rv32_pkg::ST_FIX) && !flush) begin
            r_result <= r_special ? r_spec_val : w_fixed;
            r_rd_out <= r_rd;
        end
    end

    assign result = r_result;
    assign rd_out = r_rd_out;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_iter_unit.sv
// ============================================================================
//  Module      : tb_muldiv_iter_unit
//  Description : Self-checking bench for muldiv_iter_unit: directed corner
//                cases plus random operations against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_iter_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [2:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_exp = '0;

    muldiv_iter_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .flush  (flush),
        .op     (op),
        .opa    (opa),
        .opb    (opb),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Architectural RV32M results from plain integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        longint             x;
        longint             y;
        longint             p;
        logic [63:0]        up;
        sa = a;
        sb = b;
        x  = sa;
        y  = sb;
        case (o)
            3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
            3'd1: begin p = x * y; return p[63:32]; end
            3'd2: begin y = {32'b0, b}; p = x * y; return p[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = x / y; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = x % y; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] a,
                                      input logic [31:0] b);
        if (!o[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return (o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // Called just after the start edge; counts cycles until done, optionally
    // pulsing a spurious start during the run
    task automatic wait_done(input int poke_at, output int lat, output int bcnt,
                             output bit seen);
        lat  = 0;
        bcnt = 0;
        seen = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (poke_at != 0 && k == poke_at) begin
                start = 1'b1; op = 3'd0; rd_in = 5'd31; opa = $urandom; opb = $urandom;
            end else if (poke_at != 0 && k == poke_at + 1) begin
                start = 1'b0;
            end
            if (busy) bcnt++;
            if (done) begin
                lat  = k;
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input int poke_at);
        logic [31:0] exp;
        bit          spec;
        int          lat;
        int          bcnt;
        bit          seen;
        exp  = ref_model(o, a, b);
        spec = is_special(o, a, b);
        @(negedge clk);
        op = o; opa = a; opb = b; rd_in = r; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = 3'($urandom); opa = $urandom; opb = $urandom; rd_in = 5'($urandom);
        wait_done(poke_at, lat, bcnt, seen);
        chk($sformatf("done_seen op%0d", o), 32'(seen), 32'd1);
        chk($sformatf("latency op%0d", o), lat, spec ? 32'd2 : 32'd34);
        chk($sformatf("busy_cycles op%0d", o), bcnt, spec ? 32'd1 : 32'd33);
        chk($sformatf("result op%0d %08h %08h", o, a, b), result, exp);
        chk($sformatf("rd_out op%0d", o), 32'(rd_out), 32'(r));
        @(negedge clk);
        chk($sformatf("done_pulse op%0d", o), 32'(done), 32'd0);
        chk($sformatf("result_hold op%0d", o), result, exp);
        last_exp = exp;
    endtask

    initial begin
        int          n_done;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;
        int          lat;
        int          bcnt;
        bit          seen;

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; opa = '0; opb = '0; rd_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_rd_out", 32'(rd_out), 32'd0);
        rst_n = 1'b1;

        // Directed arithmetic cases
        run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 0);
        run_op(3'd5, 32'd100, 32'd7, 5'd11, 0);
        run_op(3'd7, 32'd100, 32'd7, 5'd12, 0);
        run_op(3'd5, 32'd5, 32'd0, 5'd13, 0);
        run_op(3'd6, 32'd5, 32'd0, 5'd14, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 0);

        // Spurious start while running must not disturb the operation
        run_op(3'd0, 32'd1234, 32'd5678, 5'd17, 5);

        // Flush during a divide: no done, result untouched
        @(negedge clk);
        op = 3'd5; opa = 32'd1000; opb = 32'd3; rd_in = 5'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        chk("busy_before_flush", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("busy_after_flush", 32'(busy), 32'd0);
        chk("done_after_flush", 32'(done), 32'd0);
        chk("result_after_flush", result, last_exp);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("no_done_after_flush", n_done, 32'd0);
        run_op(3'd0, 32'd3, 32'd4, 5'd18, 0);

        // Flush with start in IDLE: start ignored
        @(negedge clk);
        op = 3'd0; opa = 32'd9; opb = 32'd9; rd_in = 5'd19; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        chk("flush_start_ignored", 32'(busy), 32'd0);

        // Start held during the done cycle is taken one cycle later
        @(negedge clk);
        op = 3'd5; opa = 32'd5; opb = 32'd0; rd_in = 5'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("special_done", 32'(done), 32'd1);
        op = 3'd0; opa = 32'd3; opb = 32'd4; rd_in = 5'd9; start = 1'b1;
        @(posedge clk);
        #1;
        chk("start_in_done_ignored", 32'(busy), 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        chk("start_after_done_taken", 32'(busy), 32'd1);
        wait_done(0, lat, bcnt, seen);
        chk("b2b_latency", lat, 32'd34);
        chk("b2b_result", result, 32'd12);
        chk("b2b_rd_out", 32'(rd_out), 32'd9);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        op = 3'd0; opa = 32'd77; opb = 32'd88; rd_in = 5'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_busy", 32'(busy), 32'd0);
        chk("areset_done", 32'(done), 32'd0);
        chk("areset_result", result, 32'd0);
        chk("areset_rd_out", 32'(rd_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21, 0);

        // Random operations, biased towards the divide corner cases
        for (int i = 0; i < 24; i++) begin
            ro  = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = $urandom_range(1, 15);
            run_op(ro, ra, rb, 5'($urandom), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/muldiv_iter_unit.md
Name: muldiv_iter_unit

Overview:
- Iterative RV32M multiply/divide engine in the MEM stage, downstream of the EX/MEM pipeline register.
- Consumes the registered mult-start strobe, funct3, operands and rd.
- Runs one radix-2 step per cycle and stalls the pipeline until the result is ready.
- Returns a 32-bit result plus destination rd to the MEM/WB path with a one-cycle done pulse.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  launch request; sampled only in IDLE.
- flush  in  1  pipeline flush; aborts any operation in progress.
- op  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- opa  in  XLEN  rs1 value.
- opb  in  XLEN  rs2 value.
- rd_in  in  5  destination register.
- busy  out  1  operation in flight; drives the pipeline stall.
- done  out  1  one-cycle pulse; result and rd_out are valid while it is high.
- result  out  XLEN  final value.
- rd_out  out  5  destination register, captured at start.

Behaviour:
- Reset: state = IDLE; busy, done, result, rd_out, counter and datapath registers all 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1, flush=0:
  - Latch op and rd_in.
  - Compute operand magnitudes from op signedness: MULH signs both operands, MULHSU signs opa only, DIV/REM sign both, all others unsigned.
  - Record the result sign.
  - Go to CALC with counter = 0; busy rises on the same edge.
- Special divides (op 4-7) are detected at start and skip CALC, going straight to FIX:
  - opb = 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give opa.
  - DIV/REM with opa = 0x80000000 and opb = 0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- CALC performs one step per cycle and leaves after exactly XLEN steps (counter reaches XLEN-1, then next state FIX):
  - Multiply: 64-bit shift-add on the magnitudes.
  - Divide: restoring shift-subtract producing quotient and remainder.
- FIX:
  - Apply two's-complement sign correction. Quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - Select the result: low word for MUL, high word for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU.
  - Register result and assert done. Next state DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Latency, counted from the start edge E:
  - Normal operation: done is high in the cycle following edge E+33.
  - Special divide: done is high in the cycle following edge E+1.
- busy is high from edge E until the edge that asserts done.
- result and rd_out hold their values after done until the next FIX.
- start while not IDLE is ignored; the upstream pipeline is stalled by busy.
- flush in any state: return to IDLE next edge, clear busy, no done pulse; result is unchanged.
- flush together with start in IDLE: start is ignored.
- start on the cycle done is high (DONE state) is ignored; it is accepted one cycle later in IDLE.
- Asynchronous reset mid-operation: immediate return to the reset values, no done pulse.

Decomposition:
- Shared package rv32_pkg:
  - enum muldiv_op_e, with the funct3 encodings above.
  - enum muldiv_state_e.
  - Constants XLEN = 32, DIV_OVF_QUOT = 32'h8000_0000, ALL_ONES = 32'hFFFF_FFFF.
- One natural sub-module, muldiv_sign_fix: combinational abs/negate and result select used in FIX. Everything else stays in this block.

Test Plan:
- MUL 7 x -3 (opa=0x00000007, opb=0xFFFFFFFD), start one cycle -> done exactly 34 cycles after the start edge, result 0xFFFFFFEB, busy high for 33 cycles, rd_out = rd_in.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 % 7 -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 % 0 -> 5, done one cycle after start; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
- Start DIVU, assert flush at cycle 10 -> busy low next cycle, no done pulse; new MUL 3 x 4 issued afterwards -> 12. A start pulse at cycle 5 of a running op is ignored.
- Deassert rst_n asynchronously mid-CALC -> busy, done, result, rd_out immediately 0; the following MULU-family op completes normally.
